display_scanout: RTL and testbench
==================================

DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 SHALL have parameter FB_OFFSET, default 12'h100, framebuffer base address.
REQ-002 SHALL have parameter FB_BYTES, default 256, framebuffer length in bytes (64x32 pixels, 1 bit/pixel).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  run continuous frame scanout while high.
REQ-006 SHALL have port scan_mem_read  output  1  memory read request.
REQ-007 SHALL have port scan_mem_read_addr  output  12  read address.
REQ-008 SHALL have port scan_mem_read_data  input  8  read data, valid in the ack cycle.
REQ-009 SHALL have port scan_mem_read_ack  input  1  read completion strobe.
REQ-010 SHALL have port pixel_out  output  1  pixel value (1 = lit).
REQ-011 SHALL have port pixel_x  output  6  pixel column 0..63.
REQ-012 SHALL have port pixel_y  output  5  pixel row 0..31.
REQ-013 SHALL have port pixel_valid  output  1  pixel beat offered.
REQ-014 SHALL have port pixel_ready  input  1  sink accepts beat.
REQ-015 SHALL have port frame_start  output  1  high with the first beat (x=0,y=0) of a frame.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last beat of a frame.

Function
REQ-017 SHALL implement states IDLE, FETCH, STREAM; IDLE->FETCH when enable=1; FETCH->STREAM on ack of byte 0; STREAM->FETCH (next frame) or IDLE after last beat, per enable sampled then.
REQ-018 SHALL assert scan_mem_read the cycle after leaving IDLE, holding address stable until ack; scan_mem_read drops the cycle after ack and stays low at least one cycle before the next request.
REQ-019 SHALL capture scan_mem_read_data only in a cycle with scan_mem_read=1 and ack=1; ack while scan_mem_read=0 SHALL be ignored.
REQ-020 SHALL read byte n (0..FB_BYTES-1) at FB_OFFSET+n; 8-bit byte counter wraps 255->0 at frame end; address never leaves FB_OFFSET..FB_OFFSET+255.
REQ-021 SHALL hold a shift register (current byte) plus a one-byte prefetch buffer with valid flag; next read issued whenever the buffer is empty and bytes remain in the frame.
REQ-022 SHALL map byte n, bit b (7=MSB) to y=n/8, x=(n%8)*8+(7-b); MSB leftmost.
REQ-023 SHALL transfer a beat when pixel_valid=1 and pixel_ready=1; pixel_out/x/y SHALL be stable while valid=1 and ready=0.
REQ-024 SHALL present the first beat of a byte the cycle after its ack (empty pipeline) or the cycle after the previous byte's bit 0 transfers (buffer full); with ready held high and acks one cycle after request, stream SHALL be gapless after byte 0.
REQ-025 SHALL deassert pixel_valid when the shift register is exhausted and the buffer empty (memory stall).
REQ-026 SHALL pulse frame_done one cycle after the transfer of (x=63,y=31).
REQ-027 SHALL complete the current frame when enable falls mid-frame, then enter IDLE.

Reset
REQ-028 SHALL on rst=1 immediately force: state IDLE, scan_mem_read=0, scan_mem_read_addr=FB_OFFSET, pixel_valid=0, pixel_out=0, pixel_x=0, pixel_y=0, frame_start=0, frame_done=0, buffer valid=0, byte counter=0.
REQ-029 SHALL abandon an outstanding read on reset; a late ack after reset release with scan_mem_read=0 SHALL be ignored.

Structure
REQ-030 SHALL take framebuffer offset, length, width 64, height 32 from the shared include gpu_defs.v, also used by gpu.
REQ-031 SHALL isolate shift register plus prefetch buffer in one sub-module scanout_byte_buffer (load, shift, empty/full flags).

Verification
REQ-032 Memory holds 0x80 at 0x100, zeros elsewhere, ready=1, ack 1 cycle after read -> first beat x=0,y=0,pixel=1,frame_start=1; other 2047 beats pixel=0; frame_done once.
REQ-033 Byte 0x109=0x01 -> only lit beat is x=15,y=1.
REQ-034 pixel_ready low for 5 cycles mid-byte -> pixel_out/x/y unchanged for those cycles, no beat lost or duplicated.
REQ-035 Ack delayed 10 cycles for byte 37 -> read addr 0x125 held stable 10 cycles, pixel_valid drops then resumes at x=40,y=4.
REQ-036 rst asserted with scan_mem_read=1 at addr 0x180, then released -> outputs at REQ-028 values; next frame restarts at addr 0x100.
REQ-037 enable low at beat 1000 -> frame completes (2048 beats, frame_done), then IDLE with scan_mem_read=0.

Source files
------------

// File: rtl/display_scanout_pkg.sv
// display_scanout shared definitions
// framebuffer geometry and scanout FSM states
package display_scanout_pkg;

  localparam logic [11:0] FB_BASE = 12'h100;
  localparam int          FB_LEN  = 256;
  localparam int          FB_W    = 64;
  localparam int          FB_H    = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } scan_state_t;

endpackage

// File: rtl/scanout_byte_buffer.sv
// display_scanout byte pipeline
// pixel shift register with one-byte prefetch slot
module scanout_byte_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_shift,
  output logic       o_bit,
  output logic       o_sr_valid,
  output logic       o_buf_full,
  output logic       o_empty
);

  logic [7:0] r_sr;
  logic [3:0] r_bits;
  logic [7:0] r_buf;
  logic       r_buf_v;
  logic       w_drain;
  logic       w_free;

  assign w_drain = i_shift & (r_bits == 4'd1);
  assign w_free  = (r_bits == 4'd0) | w_drain;

  // shift out MSB first; refill from prefetch or
  // straight from memory when both stages are free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= 8'd0;
      r_bits  <= 4'd0;
      r_buf   <= 8'd0;
      r_buf_v <= 1'b0;
    end else begin
      if (i_shift && r_bits != 4'd0) begin
        r_sr   <= {r_sr[6:0], 1'b0};
        r_bits <= r_bits - 4'd1;
      end
      if (w_free) begin
        if (r_buf_v) begin
          r_sr    <= r_buf;
          r_bits  <= 4'd8;
          r_buf_v <= i_load;
          if (i_load) r_buf <= i_data;
        end else if (i_load) begin
          r_sr   <= i_data;
          r_bits <= 4'd8;
        end
      end else if (i_load) begin
        r_buf   <= i_data;
        r_buf_v <= 1'b1;
      end
    end
  end

  assign o_bit      = r_sr[7];
  assign o_sr_valid = (r_bits != 4'd0);
  assign o_buf_full = r_buf_v;
  assign o_empty    = ~o_sr_valid & ~r_buf_v;

endmodule

// File: rtl/display_scanout.sv
// display_scanout top
// streams the 1bpp framebuffer as x/y pixel beats
module display_scanout
  import display_scanout_pkg::*;
#(
  parameter logic [11:0] FB_OFFSET = FB_BASE,
  parameter int          FB_BYTES  = FB_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        scan_mem_read,
  output logic [11:0] scan_mem_read_addr,
  input  logic [7:0]  scan_mem_read_data,
  input  logic        scan_mem_read_ack,
  output logic        pixel_out,
  output logic [5:0]  pixel_x,
  output logic [4:0]  pixel_y,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_start,
  output logic        frame_done
);

  localparam int XW = $clog2(FB_W);
  localparam logic [7:0] LAST_BYTE =
    8'(FB_BYTES - 1);
  localparam logic [10:0] LAST_BEAT =
    11'(FB_BYTES * 8 - 1);

  scan_state_t r_state;
  logic        r_rd;
  logic [11:0] r_addr;
  logic [7:0]  r_cnt;
  logic        r_all;
  logic        r_gap;
  logic [10:0] r_beat;
  logic        r_done;

  logic w_accept;
  logic w_xfer;
  logic w_last;
  logic w_issue;
  logic w_bit;
  logic w_sr_valid;
  logic w_buf_full;
  logic w_empty;

  assign w_accept = r_rd & scan_mem_read_ack;
  assign w_xfer   = w_sr_valid & pixel_ready;
  assign w_last   = w_xfer & (r_beat == LAST_BEAT);
  assign w_issue  = (r_state != S_IDLE) & ~r_rd &
                    ~r_gap & ~w_buf_full & ~r_all;

  scanout_byte_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_data     (scan_mem_read_data),
    .i_shift    (w_xfer),
    .o_bit      (w_bit),
    .o_sr_valid (w_sr_valid),
    .o_buf_full (w_buf_full),
    .o_empty    (w_empty)
  );

  // frame FSM, read requester and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b0;
      r_addr  <= FB_OFFSET;
      r_cnt   <= 8'd0;
      r_all   <= 1'b0;
      r_gap   <= 1'b0;
      r_beat  <= 11'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_gap  <= w_accept;
      if (w_issue) begin
        r_rd   <= 1'b1;
        r_addr <= FB_OFFSET + {4'd0, r_cnt};
      end
      if (w_accept) begin
        r_rd  <= 1'b0;
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == LAST_BYTE) begin
          r_all <= 1'b1;
          r_cnt <= 8'd0;
        end
      end
      if (w_xfer)
        r_beat <= w_last ? 11'd0 : r_beat + 11'd1;
      if (w_last) begin
        r_done <= 1'b1;
        r_all  <= 1'b0;
      end
      unique case (r_state)
        S_IDLE:
          if (enable) r_state <= S_FETCH;
        S_FETCH:
          if (w_accept) r_state <= S_STREAM;
        S_STREAM:
          if (w_last)
            r_state <= enable ? S_FETCH : S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_empty;

  assign scan_mem_read      = r_rd;
  assign scan_mem_read_addr = r_addr;
  assign pixel_out          = w_bit;
  assign pixel_valid        = w_sr_valid;
  assign pixel_x            = r_beat[XW-1:0];
  assign pixel_y            = r_beat[10:XW];
  assign frame_start        = w_sr_valid &
                              (r_beat == 11'd0);
  assign frame_done         = r_done;

endmodule

// File: tb/tb_display_scanout.sv
// display_scanout testbench
// scoreboard of expected beats, memory responder
module tb_display_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        scan_mem_read;
  logic [11:0] scan_mem_read_addr;
  logic [7:0]  scan_mem_read_data;
  logic        scan_mem_read_ack;
  logic        pixel_out;
  logic [5:0]  pixel_x;
  logic [4:0]  pixel_y;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        frame_start;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scanout dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .scan_mem_read      (scan_mem_read),
    .scan_mem_read_addr (scan_mem_read_addr),
    .scan_mem_read_data (scan_mem_read_data),
    .scan_mem_read_ack  (scan_mem_read_ack),
    .pixel_out          (pixel_out),
    .pixel_x            (pixel_x),
    .pixel_y            (pixel_y),
    .pixel_valid        (pixel_valid),
    .pixel_ready        (pixel_ready),
    .frame_start        (frame_start),
    .frame_done         (frame_done)
  );

  typedef struct packed {
    logic       p;
    logic [5:0] x;
    logic [4:0] y;
    logic       fs;
  } beat_t;

  beat_t      q[$];
  logic [7:0] mem[256];

  int n_chk = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int frames_done = 0;
  int fd_cnt = 0;
  int stall_beat = -1;
  int hold37 = 0;
  int addr_unstable = 0;
  int exp_byte = 0;
  int age = 0;
  int lim;
  logic        due = 1'b0;
  logic        slow37 = 1'b0;
  logic        inject_ack = 1'b0;
  logic [11:0] held;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic push_frame();
    beat_t e;
    for (int n = 0; n < 256; n++)
      for (int b = 7; b >= 0; b--) begin
        e.p  = mem[n][b];
        e.x  = 6'((n % 8) * 8 + (7 - b));
        e.y  = 5'(n / 8);
        e.fs = (n == 0) && (b == 7);
        q.push_back(e);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int nb);
    for (int i = 0; i < 4000 && beats_seen < nb; i++)
      step();
    chk("beat_timeout", 32'(beats_seen >= nb), 1);
  endtask

  task automatic wait_frames(input int nf);
    for (int i = 0; i < 6000 && frames_done < nf; i++)
      step();
    chk("frame_timeout", 32'(frames_done >= nf), 1);
  endtask

  task automatic chk_idle(input string nm);
    repeat (5) step();
    chk({nm, "_read"}, 32'(scan_mem_read), 0);
    chk({nm, "_valid"}, 32'(pixel_valid), 0);
  endtask

  task automatic monitor();
    beat_t a;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats_seen = 0;
        due = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (due) begin
          chk("frame_done", 32'(frame_done), 1);
          due = 1'b0;
        end else if (frame_done) begin
          chk("frame_done_extra", 32'(frame_done), 0);
        end
        if (!pixel_valid && beats_seen > 0 &&
            beats_seen < 2048 && stall_beat < 0)
          stall_beat = beats_seen;
        if (pixel_valid) begin
          a = '{pixel_out, pixel_x, pixel_y,
                frame_start};
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_extra: got %h expected none",
                     a);
          end else begin
            chk("beat", 32'(a), 32'(q[0]));
            if (pixel_ready) begin
              void'(q.pop_front());
              beats_seen++;
              if (beats_seen == 2048) begin
                beats_seen = 0;
                frames_done++;
                due = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic responder();
    forever begin
      @(negedge clk);
      scan_mem_read_ack  = 1'b0;
      scan_mem_read_data = 8'h5A;
      if (rst) begin
        age = 0;
        exp_byte = 0;
      end else if (inject_ack) begin
        scan_mem_read_ack  = 1'b1;
        scan_mem_read_data = 8'hFF;
      end else if (scan_mem_read) begin
        if (age == 0) held = scan_mem_read_addr;
        else if (scan_mem_read_addr !== held)
          addr_unstable++;
        age++;
        lim = (slow37 && scan_mem_read_addr == 12'h125)
              ? 10 : 1;
        if (age > lim) begin
          scan_mem_read_ack  = 1'b1;
          scan_mem_read_data = mem[scan_mem_read_addr[7:0]];
          chk("rd_addr", 32'(scan_mem_read_addr),
              32'(12'h100 + 12'(exp_byte)));
          if (scan_mem_read_addr == 12'h125)
            hold37 = age;
          exp_byte = (exp_byte + 1) % 256;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    pixel_ready = 1'b1;
    scan_mem_read_ack = 1'b0;
    scan_mem_read_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    fork
      monitor();
      responder();
    join_none

    repeat (3) step();
    chk("rst_read", 32'(scan_mem_read), 0);
    chk("rst_addr", 32'(scan_mem_read_addr), 32'h100);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_pixel", 32'(pixel_out), 0);
    chk("rst_x", 32'(pixel_x), 0);
    chk("rst_y", 32'(pixel_y), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_fd", 32'(frame_done), 0);
    rst = 1'b0;
    chk_idle("idle_after_rst");

    // single lit pixel at origin
    mem[0] = 8'h80;
    push_frame();
    enable = 1'b1;
    wait_beats(1);
    enable = 1'b0;
    wait_frames(1);
    chk_idle("idle_a");
    chk("fd_count_a", 32'(fd_cnt), 1);

    // lit pixel at x=15,y=1 with a sink stall
    mem[0] = 8'h00;
    mem[9] = 8'h01;
    push_frame();
    enable = 1'b1;
    wait_beats(100);
    pixel_ready = 1'b0;
    repeat (5) step();
    pixel_ready = 1'b1;
    enable = 1'b0;
    wait_frames(2);
    chk_idle("idle_b");

    // slow ack on byte 37
    mem[9]  = 8'h00;
    mem[0]  = 8'hA5;
    mem[37] = 8'hFF;
    slow37 = 1'b1;
    stall_beat = -1;
    push_frame();
    enable = 1'b1;
    wait_beats(1);
    enable = 1'b0;
    wait_frames(3);
    slow37 = 1'b0;
    chk("stall_beat", 32'(stall_beat), 296);
    chk("hold37", 32'(hold37 >= 10), 1);
    chk("addr_stable", 32'(addr_unstable), 0);
    chk_idle("idle_c");

    // reset with a read outstanding at 0x180
    push_frame();
    enable = 1'b1;
    for (int i = 0; i < 3000 &&
         !(scan_mem_read &&
           scan_mem_read_addr == 12'h180); i++)
      step();
    chk("saw_180", 32'(scan_mem_read_addr), 32'h180);
    @(posedge clk);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("arst_read", 32'(scan_mem_read), 0);
    chk("arst_addr", 32'(scan_mem_read_addr), 32'h100);
    chk("arst_valid", 32'(pixel_valid), 0);
    chk("arst_xy", 32'({pixel_x, pixel_y}), 0);
    q.delete();
    inject_ack = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    inject_ack = 1'b0;
    chk_idle("idle_d");

    // enable drops at beat 1000
    push_frame();
    enable = 1'b1;
    wait_beats(1000);
    enable = 1'b0;
    wait_frames(4);
    chk_idle("idle_e");
    chk("fd_count", 32'(fd_cnt), 4);
    chk("queue_empty", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
